// File: rtl/array_scan_reader_if.sv
// Signal bundle between array_scan_reader and its environment: scan
// request, array-controller command/completion and the per-cell result stream.
// Optional build macro: SCAN_BIT_EN adds the thresholded rd_bit output.
interface array_scan_reader_if;
    logic       start;
    logic [9:0] addr_start;
    logic [9:0] addr_end;
    logic [7:0] v_read;
    logic       work_en;
    logic       op_mode;
    logic       work_mode;
    logic [9:0] addr_out;
    logic [7:0] v_wl;
    logic       work_down;
    logic [7:0] i_read;
    logic       rd_valid;
    logic       rd_ready;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
`ifdef SCAN_BIT_EN
    logic       rd_bit;
`endif
    logic       busy;
    logic       done;
    logic       err;

    // Reader side
    modport master (
        input  start, addr_start, addr_end, v_read, work_down, i_read, rd_ready,
`ifdef SCAN_BIT_EN
        output rd_bit,
`endif
        output work_en, op_mode, work_mode, addr_out, v_wl,
        output rd_valid, rd_addr, rd_data, busy, done, err
    );

    // Environment side (array controller, result consumer, host)
    modport slave (
        output start, addr_start, addr_end, v_read, work_down, i_read, rd_ready,
`ifdef SCAN_BIT_EN
        input  rd_bit,
`endif
        input  work_en, op_mode, work_mode, addr_out, v_wl,
        input  rd_valid, rd_addr, rd_data, busy, done, err
    );
endinterface

// File: rtl/array_scan_reader.sv
// array_scan_reader: walks cell addresses addr_start..addr_end (wrapping
// modulo 1024), issues one array read per cell, waits for work_down with a
// per-cell timeout, and streams (address, current) results over a
// valid/ready channel.
// Optional build macro: SCAN_BIT_EN adds rd_bit = (captured i_read >= THRESH).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | work_en raised for the current address, timeout loaded
// WAIT  | work_en held, waiting for work_down or timeout
// PUSH  | result held on rd_* until rd_valid && rd_ready
// FIN   | done pulse visible, busy drops on leaving
module array_scan_reader #(
    parameter int TIMEOUT_CYC = 64
`ifdef SCAN_BIT_EN
    , parameter logic [7:0] THRESH = 8'd128
`endif
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    array_scan_reader_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH,
        S_FIN
    } state_t;

    state_t        state_q;
    logic [9:0]    addr_q;
    logic [9:0]    end_q;
    logic [7:0]    v_wl_q;
    logic [TW-1:0] tmr_q;
    logic          work_en_q;
    logic          rd_valid_q;
    logic [9:0]    rd_addr_q;
    logic [7:0]    rd_data_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
`ifdef SCAN_BIT_EN
    logic          rd_bit_q;
`endif

    // Scan sequencer: state, timeout down-counter and all registered outputs.
    // The timer is loaded with TIMEOUT_CYC-1 on entry to ISSUE so that work_en
    // is high for exactly TIMEOUT_CYC cycles when work_down never arrives.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            v_wl_q     <= '0;
            tmr_q      <= '0;
            work_en_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SCAN_BIT_EN
            rd_bit_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        addr_q    <= bus.addr_start;
                        end_q     <= bus.addr_end;
                        v_wl_q    <= bus.v_read;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        work_en_q <= 1'b1;
                        tmr_q     <= TW'(TIMEOUT_CYC - 1);
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.work_down) begin
                        rd_data_q  <= bus.i_read;
                        rd_addr_q  <= addr_q;
`ifdef SCAN_BIT_EN
                        rd_bit_q   <= (bus.i_read >= THRESH);
`endif
                        work_en_q  <= 1'b0;
                        rd_valid_q <= 1'b1;
                        state_q    <= S_PUSH;
                    end else if (tmr_q == '0) begin
                        rd_data_q  <= 8'hFF;
                        rd_addr_q  <= addr_q;
`ifdef SCAN_BIT_EN
                        rd_bit_q   <= 1'b0;
`endif
                        err_q      <= 1'b1;
                        work_en_q  <= 1'b0;
                        rd_valid_q <= 1'b1;
                        state_q    <= S_PUSH;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_PUSH: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (addr_q == end_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            addr_q    <= addr_q + 1'b1;
                            work_en_q <= 1'b1;
                            tmr_q     <= TW'(TIMEOUT_CYC - 1);
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.work_en   = work_en_q;
    assign bus.op_mode   = 1'b0;
    assign bus.work_mode = 1'b1;
    assign bus.addr_out  = addr_q;
    assign bus.v_wl      = v_wl_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
`ifdef SCAN_BIT_EN
    assign bus.rd_bit    = rd_bit_q;
`endif

endmodule

// File: tb/tb_array_scan_reader.sv
// Bench for array_scan_reader: an array-controller responder answers each
// read after a per-address lag with per-address data; expected beats, data,
// work_en lengths and err are derived from the scan rules over those tables.
// Build with SCAN_BIT_EN defined to also check rd_bit.
module tb_array_scan_reader;
    localparam int TMO = 8;
    localparam int THR = 128;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    logic       st = 1'b0;
    logic [9:0] as = '0;
    logic [9:0] ae = '0;
    logic [7:0] vr = '0;
    logic       wd = 1'b0;
    logic [7:0] ir = '0;
    logic       rdy = 1'b0;

    array_scan_reader_if bus();

    assign bus.start      = st;
    assign bus.addr_start = as;
    assign bus.addr_end   = ae;
    assign bus.v_read     = vr;
    assign bus.work_down  = wd;
    assign bus.i_read     = ir;
    assign bus.rd_ready   = rdy;

    array_scan_reader #(.TIMEOUT_CYC(TMO)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [1024];
    int         lag [1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Array controller: work_down pulses in the (1+lag)-th cycle of work_en.
    int wcnt = 0;
    always @(negedge sys_clk) begin
        if (bus.work_en) begin
            wcnt = wcnt + 1;
            if (wcnt == lag[bus.addr_out] + 1) begin
                wd = 1'b1;
                ir = mem[bus.addr_out];
            end else begin
                wd = 1'b0;
                ir = 8'($urandom);
            end
        end else begin
            wcnt = 0;
            wd   = 1'b0;
            ir   = 8'($urandom);
        end
    end

    // rmode: 0 always ready, 1 random ready, 2 stall the first 5 valid cycles.
    task automatic run_scan(input logic [9:0] s, input logic [9:0] e, input logic [7:0] v,
                            input int rmode, input bit poke);
        logic [9:0] eaddr[$];
        logic [7:0] edata[$];
        int         elen[$];
        bit         ebit[$];
        bit         eerr = 1'b0;
        int         a = int'(s);
        int         beats = 0, cyc = 0, en_run = 0, vcnt = 0, budget;
        bit         pv = 1'b0, fin = 1'b0, to;
        logic [9:0] pa = '0;
        logic [7:0] pd = '0;

        while (1) begin
            to = (lag[a] < 1) || (lag[a] >= TMO);
            eaddr.push_back(10'(a));
            edata.push_back(to ? 8'hFF : mem[a]);
            elen.push_back(to ? TMO : lag[a] + 1);
            ebit.push_back(!to && (int'(mem[a]) >= THR));
            if (to) eerr = 1'b1;
            if (a == int'(e)) break;
            a = (a + 1) % 1024;
        end
        budget = 40 * eaddr.size() + 40;

        @(negedge sys_clk);
        st = 1'b1; as = s; ae = e; vr = v;
        @(negedge sys_clk);
        st = 1'b0; as = 10'($urandom); ae = 10'($urandom); vr = 8'($urandom);
        chk("busy_on_start", bus.busy, 1);
        chk("err_cleared", bus.err, 0);
        chk("v_wl", bus.v_wl, v);
        chk("first_addr_out", bus.addr_out, s);
        chk("issue_work_en", bus.work_en, 1);

        while (!fin && cyc < budget) begin
            if (bus.work_en) en_run++;
            if (pv) begin
                chk("hold_valid", bus.rd_valid, 1);
                chk("hold_addr", bus.rd_addr, pa);
                chk("hold_data", bus.rd_data, pd);
            end
            if (bus.rd_valid) begin
                chk("push_work_en", bus.work_en, 0);
                if (!pv && beats < elen.size()) begin
                    chk("work_en_len", en_run, elen[beats]);
                    en_run = 0;
                end
                vcnt++;
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = (vcnt > 5);
                endcase
                if (rdy) begin
                    if (beats < eaddr.size()) begin
                        chk("beat_addr", bus.rd_addr, eaddr[beats]);
                        chk("beat_data", bus.rd_data, edata[beats]);
`ifdef SCAN_BIT_EN
                        chk("beat_bit", bus.rd_bit, ebit[beats]);
`endif
                    end else begin
                        chk("extra_beat", beats, eaddr.size() - 1);
                    end
                    beats++;
                    pv = 1'b0;
                end else begin
                    pv = 1'b1;
                    pa = bus.rd_addr;
                    pd = bus.rd_data;
                end
            end else begin
                pv  = 1'b0;
                rdy = 1'($urandom_range(0, 1));
            end
            if (bus.done) begin
                chk("beats_at_done", beats, eaddr.size());
                chk("err_at_done", bus.err, eerr);
                fin = 1'b1;
            end
            if (poke && cyc == 4) begin
                st = 1'b1;
                as = 10'($urandom); ae = 10'($urandom); vr = 8'($urandom);
            end else begin
                st = 1'b0;
            end
            @(negedge sys_clk);
            cyc++;
        end
        st = 1'b0;
        chk("scan_completed", fin, 1);
        chk("done_one_cycle", bus.done, 0);
        chk("busy_after_done", bus.busy, 0);
        chk("valid_after_done", bus.rd_valid, 0);
        chk("err_after_done", bus.err, eerr);
        chk("v_wl_held", bus.v_wl, v);
    endtask

    initial begin
        int s, n;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            lag[i] = 2;
        end

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_work_en", bus.work_en, 0);
        chk("rst_op_mode", bus.op_mode, 0);
        chk("rst_work_mode", bus.work_mode, 1);
        chk("rst_addr_out", bus.addr_out, 0);
        chk("rst_v_wl", bus.v_wl, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
`ifdef SCAN_BIT_EN
        chk("rst_rd_bit", bus.rd_bit, 0);
`endif
        sys_rst_n = 1'b1;

        // Four cells, data = addr*10, answer two cycles after work_en
        for (int i = 6; i <= 9; i++) begin
            mem[i] = 8'(i * 10);
            lag[i] = 2;
        end
        run_scan(10'd6, 10'd9, 8'h5A, 0, 1'b0);

        // Wrap through 1023 to 0, random lags/data/backpressure
        for (int i = 0; i < 4; i++) begin
            lag[(1022 + i) % 1024] = int'($urandom_range(1, 6));
        end
        run_scan(10'd1022, 10'd1, 8'h33, 1, 1'b0);

        // Single cell, work_down never comes
        lag[100] = 20;
        run_scan(10'd100, 10'd100, 8'h11, 0, 1'b0);

        // work_down only during ISSUE is ignored, so this also times out
        lag[101] = 0;
        run_scan(10'd101, 10'd101, 8'h12, 0, 1'b0);

        // Backpressure for 5 cycles on the first beat plus a start pulse mid-scan
        for (int i = 300; i <= 303; i++) lag[i] = 1;
        run_scan(10'd300, 10'd303, 8'h77, 2, 1'b1);

        // Threshold edge
        mem[500] = 8'd127; lag[500] = 1;
        mem[501] = 8'd128; lag[501] = 1;
        run_scan(10'd500, 10'd501, 8'h40, 0, 1'b0);

        // Reset while waiting for work_down
        lag[700] = 5;
        @(negedge sys_clk);
        st = 1'b1; as = 10'd700; ae = 10'd702; vr = 8'h99;
        @(negedge sys_clk);
        st = 1'b0;
        @(negedge sys_clk);
        chk("pre_rst_work_en", bus.work_en, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_rst_work_en", bus.work_en, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_addr_out", bus.addr_out, 0);
        chk("async_rst_v_wl", bus.v_wl, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("no_done_in_rst", bus.done, 0);
        end
        sys_rst_n = 1'b1;
        for (int i = 40; i <= 45; i++) lag[i] = int'($urandom_range(1, 6));
        run_scan(10'd40, 10'd45, 8'hC3, 1, 1'b0);

        // Random scans, occasional timeouts
        for (int k = 0; k < 4; k++) begin
            s = int'($urandom_range(0, 1023));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                lag[(s + i) % 1024] = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(1, 6));
            end
            run_scan(10'(s), 10'((s + n - 1) % 1024), 8'($urandom), 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
